// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART receive sequencer.
//               - rx_state_e : receive sequencer states
//               - PRESC_8/16/32 : the only oversampling ratios accepted
//               - STOP_IDX / PAR_IDX : bit_cnt index of the stop and parity
//                 bits for a given data width and parity setting
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } rx_state_e;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    // Bit index 0 is the start bit, 1..data_w are data, then optional parity,
    // then stop.
    function automatic int PAR_IDX(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int STOP_IDX(input int data_w, input logic par_en);
        return data_w + 1 + (par_en ? 1 : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fsm
// Description : Receive-path sequencer of the UART RX. Walks a frame through
//               START / DATA / PARITY / STOP using the sibling edge/bit
//               counter, strobes the sampler, deserializer and parity checker,
//               and reports a one-cycle frame result.
// Ports       :
//   CLK          in   RX oversampling clock
//   RST          in   asynchronous, active-low reset
//   RX_IN        in   synchronised serial line
//   PAR_EN       in   frame carries a parity bit
//   prescale     in   oversampling ratio (8/16/32 accepted)
//   edge_cnt     in   counter edge index, 0..prescale-1
//   bit_cnt      in   counter bit index, 0 = start bit
//   sampled_bit  in   majority-vote sample of the current bit
//   par_err_in   in   parity checker result, valid while par_chk_en=1
//   cnt_en       out  counter enable; low clears the counter
//   dat_samp_en  out  sampler enable
//   deser_en     out  deserializer shift strobe
//   par_chk_en   out  parity check strobe
//   data_valid   out  1-cycle pulse, good frame
//   par_err      out  1-cycle pulse, parity failure
//   stp_err      out  1-cycle pulse, framing failure
//   busy         out  high whenever the sequencer is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PRESC_W  = 6,
    parameter int BITCNT_W = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RX_IN,
    input  logic                PAR_EN,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic [PRESC_W-1:0]  edge_cnt,
    input  logic [BITCNT_W-1:0] bit_cnt,
    input  logic                sampled_bit,
    input  logic                par_err_in,
    output logic                cnt_en,
    output logic                dat_samp_en,
    output logic                deser_en,
    output logic                par_chk_en,
    output logic                data_valid,
    output logic                par_err,
    output logic                stp_err,
    output logic                busy
);

    localparam logic [BITCNT_W-1:0] c_LAST_DATA_IDX = BITCNT_W'(DATA_W);
    localparam logic [PRESC_W-1:0]  c_PRESC_8       = PRESC_W'(PRESC_8);
    localparam logic [PRESC_W-1:0]  c_PRESC_16      = PRESC_W'(PRESC_16);
    localparam logic [PRESC_W-1:0]  c_PRESC_32      = PRESC_W'(PRESC_32);
    localparam logic [PRESC_W-1:0]  c_ONE           = PRESC_W'(1);

    rx_state_e          r_state;
    rx_state_e          w_next;
    logic [PRESC_W-1:0] r_presc;
    logic               r_par;
    logic               r_perr;
    logic               r_data_valid;
    logic               r_par_err;
    logic               r_stp_err;

    logic               w_last_edge;
    logic               w_presc_legal;
    logic               w_abort;
    logic               w_start_hit;
    logic               w_in_frame;
    logic               w_stop_done;
    logic               w_dv_d;
    logic               w_pe_d;
    logic               w_se_d;

    // Phase boundaries use the ratio captured at frame start, so a live
    // prescale change cannot silently stretch or shrink the current bit.
    assign w_last_edge   = (edge_cnt == (r_presc - c_ONE));
    assign w_presc_legal = (prescale == c_PRESC_8) || (prescale == c_PRESC_16) ||
                           (prescale == c_PRESC_32);
    assign w_abort       = (r_state != IDLE) && (prescale != r_presc);
    assign w_start_hit   = (r_state == IDLE) && (w_next == START);

    // ------------------------------------------------------------------
    // State and frame-context registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_par        <= 1'b0;
            r_perr       <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_data_valid <= w_dv_d;
            r_par_err    <= w_pe_d;
            r_stp_err    <= w_se_d;

            if (w_start_hit) begin
                r_presc <= prescale;
                r_par   <= PAR_EN;
            end

            if (w_start_hit || w_abort) begin
                r_perr <= 1'b0;
            end else if ((r_state == PARITY) && w_last_edge) begin
                r_perr <= par_err_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!RX_IN && w_presc_legal) begin
                        w_next = START;
                    end
                end
                START: begin
                    // A high sample in the middle of the start bit means the
                    // falling edge was noise.
                    if (w_last_edge) begin
                        w_next = sampled_bit ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (w_last_edge && (bit_cnt == c_LAST_DATA_IDX)) begin
                        w_next = r_par ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (w_last_edge) begin
                        w_next = STOP;
                    end
                end
                STOP: begin
                    // A low stop bit may be a break; wait for the line to
                    // idle before accepting another start.
                    if (w_last_edge) begin
                        w_next = sampled_bit ? IDLE : BREAK_WAIT;
                    end
                end
                BREAK_WAIT: begin
                    if (RX_IN) begin
                        w_next = IDLE;
                    end
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_in_frame  = 1'b0;
        cnt_en      = 1'b0;
        dat_samp_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        busy        = 1'b0;
        w_stop_done = 1'b0;
        w_dv_d      = 1'b0;
        w_pe_d      = 1'b0;
        w_se_d      = 1'b0;

        w_in_frame  = (r_state == START) || (r_state == DATA) ||
                      (r_state == PARITY) || (r_state == STOP);
        cnt_en      = w_in_frame;
        dat_samp_en = w_in_frame;
        deser_en    = (r_state == DATA) && w_last_edge;
        par_chk_en  = (r_state == PARITY) && w_last_edge;
        busy        = (r_state != IDLE);

        // Framing failure outranks a parity failure on the same frame.
        w_stop_done = (r_state == STOP) && w_last_edge && !w_abort;
        w_se_d      = w_stop_done && !sampled_bit;
        w_pe_d      = w_stop_done && sampled_bit && r_perr;
        w_dv_d      = w_stop_done && sampled_bit && !r_perr;
    end

    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fsm
// Description : Self-checking bench for uart_rx_fsm. Models the sibling
//               edge/bit counter and sampler, drives whole frames and
//               compares observed strobes and result pulses with expected
//               frame timing.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_fsm;

    localparam int DATA_W   = 8;
    localparam int PRESC_W  = 6;
    localparam int BITCNT_W = 4;

    typedef struct {
        int          p;
        bit          par;
        logic [7:0]  data;
        bit          perr;
        bit          stop;
        bit          glitch;
        int          hold;
        int          abort_kind;   // 0 none, 1 reset, 2 prescale change
        int          abort_rel;
        int          exp_kind;     // 0 none, 1 data_valid, 2 par_err, 3 stp_err
        int          exp_res;
        int          exp_pchk;
        int          exp_deser;
        int          exp_fall;
    } vec_t;

    logic                CLK = 1'b0;
    logic                RST = 1'b0;
    logic                RX_IN = 1'b1;
    logic                PAR_EN = 1'b0;
    logic [PRESC_W-1:0]  prescale = 6'd8;
    logic [PRESC_W-1:0]  edge_cnt;
    logic [BITCNT_W-1:0] bit_cnt;
    logic                sampled_bit;
    logic                par_err_in = 1'b0;
    logic                cnt_en, dat_samp_en, deser_en, par_chk_en;
    logic                data_valid, par_err, stp_err, busy;
    logic [15:0]         sbits = '0;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    uart_rx_fsm #(
        .DATA_W   (DATA_W),
        .PRESC_W  (PRESC_W),
        .BITCNT_W (BITCNT_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .prescale    (prescale),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .sampled_bit (sampled_bit),
        .par_err_in  (par_err_in),
        .cnt_en      (cnt_en),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .par_chk_en  (par_chk_en),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    // Sibling edge/bit counter and an ideal sampler returning the bit value
    // of the current bit slot.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == prescale - 6'd1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    assign sampled_bit = sbits[bit_cnt];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int p, input bit par, input logic [7:0] d,
                                input bit perr, input bit stop, input bit gl,
                                input int hold, input int ak, input int ar,
                                input int k, input int res, input int pc,
                                input int ds, input int fall);
        vec_t v;
        v.p = p; v.par = par; v.data = d; v.perr = perr; v.stop = stop;
        v.glitch = gl; v.hold = hold; v.abort_kind = ak; v.abort_rel = ar;
        v.exp_kind = k; v.exp_res = res; v.exp_pchk = pc; v.exp_deser = ds;
        v.exp_fall = fall;
        return v;
    endfunction

    // Reference model of a complete, uninterrupted frame. Rel 0 is the cycle
    // in which the line is first seen low; the frame occupies n bit slots of
    // p cycles starting one cycle later, and a result is reported in the cycle
    // right after the last slot.
    function automatic vec_t model(input vec_t v);
        vec_t e;
        int   n;
        e = v;
        n = DATA_W + 2 + (v.par ? 1 : 0);
        e.exp_kind  = !v.stop ? 3 : ((v.par && v.perr) ? 2 : 1);
        e.exp_res   = 1 + n * v.p;
        e.exp_pchk  = v.par ? (1 + (DATA_W + 1) * v.p + (v.p - 1)) : -1;
        e.exp_deser = DATA_W;
        // After a bad stop bit the line must first return high.
        e.exp_fall  = v.stop ? e.exp_res : (n * v.p + v.hold + 2);
        return e;
    endfunction

    task automatic run_frame(input string nm, input vec_t v,
                             input bit chain_in, input bit chain_out);
        int         n, r, r_max, bi, obs_kind, tot;
        int         dv_c = 0, pe_c = 0, se_c = 0, res_rel = -1;
        int         pchk_c = 0, pchk_rel = -1, deser_c = 0;
        int         fall = -1, cnt_at_fall = -1, cnt_after = 0;
        logic [7:0] rx_byte = '0;
        bit         done = 1'b0;

        n = DATA_W + 2 + (v.par ? 1 : 0);
        sbits        = '0;
        sbits[0]     = v.glitch;
        sbits[8:1]   = v.data;
        if (v.par) begin
            sbits[9]  = ^v.data;
            sbits[10] = v.stop;
        end else begin
            sbits[9]  = v.stop;
        end
        par_err_in = v.perr;
        prescale   = PRESC_W'(v.p);
        PAR_EN     = v.par;
        r_max      = 1 + 11 * v.p + v.hold + 40;
        r          = chain_in ? 1 : 0;

        while (!done && r <= r_max) begin
            @(negedge CLK);
            if (data_valid) begin dv_c++; res_rel = r; end
            if (par_err)    begin pe_c++; res_rel = r; end
            if (stp_err)    begin se_c++; res_rel = r; end
            if (res_rel >= 0 && cnt_en) cnt_after++;
            if (deser_en) begin
                deser_c++;
                rx_byte = {sampled_bit, rx_byte[7:1]};
            end
            if (par_chk_en) begin pchk_c++; pchk_rel = r; end
            if (r > 0 && !busy && fall < 0) begin
                fall        = r;
                cnt_at_fall = cnt_en ? 1 : 0;
            end

            if (chain_out && fall >= 0) begin
                RX_IN = 1'b0;      // next start bit, presented in the idle cycle
                done  = 1'b1;
            end else begin
                if (v.abort_kind == 1 && r == v.abort_rel)     RST = 1'b0;
                if (v.abort_kind == 1 && r == v.abort_rel + 1) RST = 1'b1;
                if (v.abort_kind == 2 && r == v.abort_rel)     prescale = 6'd8;
                if (v.abort_kind != 0 && r >= v.abort_rel) begin
                    RX_IN = 1'b1;
                end else if (v.glitch) begin
                    RX_IN = (r < 2) ? 1'b0 : 1'b1;
                end else begin
                    bi = (r == 0) ? 0 : (r - 1) / v.p;
                    if (bi < n)                                RX_IN = sbits[bi];
                    else if (!v.stop && r <= n * v.p + v.hold) RX_IN = 1'b0;
                    else                                       RX_IN = 1'b1;
                end
                if (fall >= 0 && r >= fall + 3) done = 1'b1;
                r++;
            end
        end

        tot      = dv_c + pe_c + se_c;
        obs_kind = (tot == 0) ? 0 : (tot > 1) ? 9 : (dv_c == 1) ? 1 : (pe_c == 1) ? 2 : 3;
        check($sformatf("%s result_kind", nm), obs_kind, v.exp_kind);
        if (v.exp_kind != 0)
            check($sformatf("%s result_cycle", nm), res_rel, v.exp_res);
        check($sformatf("%s parchk_cycle", nm), pchk_rel, v.exp_pchk);
        check($sformatf("%s parchk_count", nm), pchk_c, (v.exp_pchk >= 0) ? 1 : 0);
        if (v.exp_deser >= 0)
            check($sformatf("%s deser_count", nm), deser_c, v.exp_deser);
        if (v.exp_deser == DATA_W)
            check($sformatf("%s deser_byte", nm), int'(rx_byte), int'(v.data));
        check($sformatf("%s busy_fall_cycle", nm), fall, v.exp_fall);
        check($sformatf("%s cnt_en_at_idle", nm), cnt_at_fall, 0);
        check($sformatf("%s cnt_en_after_result", nm), cnt_after, 0);
    endtask

    vec_t vecs[9];

    initial begin
        int   seen;
        vec_t v;

        // Directed frames with hand-derived timing (rel 0 = line first low).
        vecs[0] = mk( 8, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0,  0, 0,  0, 1,  81,  -1,  8,  81);
        vecs[1] = mk(16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0,  0, 0,  0, 1, 177, 160,  8, 177);
        vecs[2] = mk(16, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0,  0, 0,  0, 2, 177, 160,  8, 177);
        vecs[3] = mk(32, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 40, 0,  0, 3, 321,  -1,  8, 362);
        vecs[4] = mk( 8, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1,  0, 0,  0, 0,  -1,  -1,  0,   9);
        vecs[5] = mk(16, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0,  0, 1, 60, 0,  -1,  -1, -1,  61);
        vecs[6] = mk(16, 1'b1, 8'h96, 1'b0, 1'b1, 1'b0,  0, 2, 70, 0,  -1,  -1, -1,  71);
        vecs[7] = mk( 8, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0,  0, 0,  0, 1,  89,  80,  8,  89);
        vecs[8] = mk( 8, 1'b1, 8'h42, 1'b1, 1'b0, 1'b0,  0, 0,  0, 3,  89,  80,  8,  90);

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset outputs",
              int'({cnt_en, dat_samp_en, deser_en, par_chk_en,
                    data_valid, par_err, stp_err, busy}), 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 9; i++)
            run_frame($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0);

        // Illegal prescale must never start a frame.
        @(negedge CLK);
        prescale = 6'd12;
        RX_IN    = 1'b0;
        seen     = 0;
        repeat (20) begin
            @(negedge CLK);
            if (busy || cnt_en) seen++;
        end
        check("illegal_prescale busy_cycles", seen, 0);
        RX_IN    = 1'b1;
        prescale = 6'd8;
        repeat (2) @(negedge CLK);

        // Back-to-back frames: second start bit arrives in the idle cycle.
        v = model(mk(16, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_frame("b2b_first", v, 1'b0, 1'b1);
        v = model(mk(16, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_frame("b2b_second", v, 1'b1, 1'b0);

        // Randomized frames against the reference model.
        for (int i = 0; i < 30; i++) begin
            v.p          = 8 << $urandom_range(0, 2);
            v.par        = 1'($urandom_range(0, 1));
            v.data       = 8'($urandom);
            v.perr       = 1'($urandom_range(0, 1));
            v.stop       = ($urandom_range(0, 3) != 0);
            v.glitch     = 1'b0;
            v.hold       = v.stop ? 0 : int'($urandom_range(0, 20));
            v.abort_kind = 0;
            v.abort_rel  = 0;
            v = model(v);
            run_frame($sformatf("rand%0d", i), v, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
                 errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
